id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage that directly consumes the forwarding unit's per-operand override selects.
- Each cycle it picks each decode operand from one of three sources: register file, EX/MEM result, or MEM/WB write-back data. It then registers the operands, immediate, addresses and control bits into EX.
- It detects load-use hazards against the instruction it holds, drives Stall_o to PC/IF-ID, and inserts a bubble.
- It keeps a saturating count of inserted load-use bubbles for performance debug.

Parameters:
- DATA_W, 32, operand/immediate width.
- CTRL_W, 8, packed control bus width; bit map defined in the shared package.
- CNT_W, 16, bubble counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- Hold_i  in  1  global freeze (e.g. memory wait); stage keeps all state.
- Flush_i  in  1  branch/jump flush; next edge loads a bubble.
- DecValid_i  in  1  decode slot holds a real instruction.
- DecRsAddr_i  in  5  decode rs.
- DecRtAddr_i  in  5  decode rt.
- DecRdAddr_i  in  5  decode rd.
- DecUsesRt_i  in  1  instruction reads rt as a source.
- DecImm_i  in  DATA_W  sign-extended immediate.
- DecCtrl_i  in  CTRL_W  packed control.
- RsData_i  in  DATA_W  register file rs read data.
- RtData_i  in  DATA_W  register file rt read data.
- DecRsOverride_i  in  2  forwarding select for rs.
- DecRtOverride_i  in  2  forwarding select for rt.
- ExMemAluResult_i  in  DATA_W  EX/MEM forward data.
- MemWbWriteData_i  in  DATA_W  MEM/WB forward data.
- Stall_o  out  1  load-use stall to PC and IF/ID.
- ExValid_o  out  1  EX slot valid.
- ExRsVal_o  out  DATA_W  registered rs operand.
- ExRtVal_o  out  DATA_W  registered rt operand.
- ExImm_o  out  DATA_W  registered immediate.
- ExCtrl_o  out  CTRL_W  registered control.
- ExDestAddr_o  out  5  resolved destination register.
- BubbleCount_o  out  CNT_W  load-use bubbles inserted.

Behaviour:
- Operand select (combinational, decode side), applied per operand:
  - 00 → register file data.
  - 10 → ExMemAluResult_i.
  - 01 → MemWbWriteData_i.
  - 11 is illegal and treated as 00; the assertion bench flags it.
- Destination resolve: RegDst bit set → DecRdAddr_i, else DecRtAddr_i; resolved at decode and registered.
- Load-use: Stall_o = ExValid_o & ExCtrl_o[MEMREAD] & (ExDestAddr_o != 0) & ((ExDestAddr_o == DecRsAddr_i) | (DecUsesRt_i & ExDestAddr_o == DecRtAddr_i)) & DecValid_i & ~Flush_i.
  - Stall_o is purely combinational from registered state plus decode inputs; zero added latency.
- Register update at posedge, in priority order:
  1. Hold_i: all registers and the counter retain their values. Stall_o is still driven from the current state.
  2. Flush_i: bubble. ExValid_o=0; ExCtrl_o=0, which clears RegWrite/MemRead/MemWrite. Data fields are don't-care but loaded with 0.
  3. Stall_o: bubble as above; BubbleCount_o += 1, saturating at all-ones.
  4. Otherwise: load the selected operands, DecImm_i, DecCtrl_i and the resolved destination. ExValid_o=DecValid_i; ExCtrl_o is forced to 0 when DecValid_i=0.
- Latency: decode inputs appear on Ex* outputs one cycle later.
- A stall lasts exactly one cycle per hazard: after the bubble, ExValid_o=0, so the condition clears. The stalled instruction re-presents the next cycle with its forwarding select now 01.
- Simultaneous Flush_i and a hazard: flush wins, Stall_o=0, counter unchanged.
- rst_i asserted, including mid-stall: all outputs 0 immediately (Stall_o falls to 0 since ExValid_o=0); BubbleCount_o=0.

Decomposition:
- Shared package holds:
  - Control bit indices: REGWRITE=0, MEMTOREG=1, MEMREAD=2, MEMWRITE=3, REGDST=4, ALUSRC=5, ALUOP=7:6.
  - Forward select encodings: FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
  - ZERO_REG=5'd0.
- One natural sub-module: operand_fwd_mux, a 3:1 select per operand, instantiated twice.

Test Plan:
- Forward select: RsData=0x11, ExMem=0x22, MemWb=0x33.
  - RsOverride=10 → ExRsVal_o=0x22 after one edge.
  - 01 → 0x33; 00 and 11 → 0x11.
- Load-use: EX holds lw with dest $8; decode add with rs=$8.
  - Stall_o=1 same cycle; next edge ExValid_o=0, ExCtrl_o=0, BubbleCount_o=1.
  - Following cycle Stall_o=0 and the add loads.
- No false stall:
  - Load to $0 with decode rs=$0 → Stall_o=0.
  - Decode rt=$8 with DecUsesRt_i=0 → Stall_o=0.
- Flush with a pending hazard: Flush_i=1 → Stall_o=0; bubble loaded; counter unchanged.
- Hold: Hold_i=1 for 3 cycles with changing decode inputs → all Ex* outputs and the counter frozen. Release → normal load next edge.
- Saturation and reset:
  - Preload count to 0xFFFF and force a hazard → stays 0xFFFF.
  - Assert rst_i mid-cycle → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: control bit map, forward
// select encodings and destination-register helpers.
package id_ex_operand_stage_pkg;

  localparam int unsigned REGWRITE = 0;
  localparam int unsigned MEMTOREG = 1;
  localparam int unsigned MEMREAD  = 2;
  localparam int unsigned MEMWRITE = 3;
  localparam int unsigned REGDST   = 4;
  localparam int unsigned ALUSRC   = 5;
  localparam int unsigned ALUOP_LO = 6;
  localparam int unsigned ALUOP_HI = 7;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef logic [4:0] regAddr_t;

  localparam regAddr_t ZERO_REG = 5'd0;

  function automatic regAddr_t resolveDest(input logic regDst, input regAddr_t rdAddr,
                                           input regAddr_t rtAddr);
    return regDst ? rdAddr : rtAddr;
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// 3:1 operand select between register file, EX/MEM and MEM/WB data.
module operand_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] rfData,
  input  logic [DATA_W-1:0] exMemData,
  input  logic [DATA_W-1:0] memWbData,
  output logic [DATA_W-1:0] operand
);

  // The unused 2'b11 code falls back to register file data.
  always_comb begin
    operand = rfData;
    case (sel)
      FWD_EXMEM: operand = exMemData;
      FWD_MEMWB: operand = memWbData;
      default:   operand = rfData;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with forwarded operand select, load-use hazard
// detection/bubble insertion and a saturating bubble counter.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Hold_i,
  input  logic              Flush_i,
  input  logic              DecValid_i,
  input  logic [4:0]        DecRsAddr_i,
  input  logic [4:0]        DecRtAddr_i,
  input  logic [4:0]        DecRdAddr_i,
  input  logic              DecUsesRt_i,
  input  logic [DATA_W-1:0] DecImm_i,
  input  logic [CTRL_W-1:0] DecCtrl_i,
  input  logic [DATA_W-1:0] RsData_i,
  input  logic [DATA_W-1:0] RtData_i,
  input  logic [1:0]        DecRsOverride_i,
  input  logic [1:0]        DecRtOverride_i,
  input  logic [DATA_W-1:0] ExMemAluResult_i,
  input  logic [DATA_W-1:0] MemWbWriteData_i,
  output logic              Stall_o,
  output logic              ExValid_o,
  output logic [DATA_W-1:0] ExRsVal_o,
  output logic [DATA_W-1:0] ExRtVal_o,
  output logic [DATA_W-1:0] ExImm_o,
  output logic [CTRL_W-1:0] ExCtrl_o,
  output logic [4:0]        ExDestAddr_o,
  output logic [CNT_W-1:0]  BubbleCount_o
);

  logic [DATA_W-1:0] rsSel;
  logic [DATA_W-1:0] rtSel;
  regAddr_t          decDest;
  logic              exIsLoad;
  logic              rsMatch;
  logic              rtMatch;
  logic              loadUse;

  logic              exValid;
  logic [DATA_W-1:0] exRsVal;
  logic [DATA_W-1:0] exRtVal;
  logic [DATA_W-1:0] exImm;
  logic [CTRL_W-1:0] exCtrl;
  regAddr_t          exDest;
  logic [CNT_W-1:0]  bubbleCnt;

  operand_fwd_mux #(.DATA_W(DATA_W)) rsMux (
    .sel       (DecRsOverride_i),
    .rfData    (RsData_i),
    .exMemData (ExMemAluResult_i),
    .memWbData (MemWbWriteData_i),
    .operand   (rsSel)
  );

  operand_fwd_mux #(.DATA_W(DATA_W)) rtMux (
    .sel       (DecRtOverride_i),
    .rfData    (RtData_i),
    .exMemData (ExMemAluResult_i),
    .memWbData (MemWbWriteData_i),
    .operand   (rtSel)
  );

  always_comb begin
    decDest  = resolveDest(DecCtrl_i[REGDST], DecRdAddr_i, DecRtAddr_i);
    exIsLoad = exValid & exCtrl[MEMREAD] & (exDest != ZERO_REG);
    rsMatch  = (exDest == DecRsAddr_i);
    rtMatch  = DecUsesRt_i & (exDest == DecRtAddr_i);
    // Flush suppresses the stall so a squashed instruction never holds IF/ID.
    loadUse  = exIsLoad & (rsMatch | rtMatch) & DecValid_i & ~Flush_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exValid   <= 1'b0;
      exRsVal   <= '0;
      exRtVal   <= '0;
      exImm     <= '0;
      exCtrl    <= '0;
      exDest    <= ZERO_REG;
      bubbleCnt <= '0;
    end else if (Hold_i) begin
      exValid   <= exValid;
    end else if (Flush_i || loadUse) begin
      exValid <= 1'b0;
      exRsVal <= '0;
      exRtVal <= '0;
      exImm   <= '0;
      exCtrl  <= '0;
      exDest  <= ZERO_REG;
      if (loadUse && (bubbleCnt != '1)) begin
        bubbleCnt <= bubbleCnt + CNT_W'(1);
      end
    end else begin
      exValid <= DecValid_i;
      exRsVal <= rsSel;
      exRtVal <= rtSel;
      exImm   <= DecImm_i;
      exCtrl  <= DecValid_i ? DecCtrl_i : '0;
      exDest  <= decDest;
    end
  end

  assign Stall_o       = loadUse;
  assign ExValid_o     = exValid;
  assign ExRsVal_o     = exRsVal;
  assign ExRtVal_o     = exRtVal;
  assign ExImm_o       = exImm;
  assign ExCtrl_o      = exCtrl;
  assign ExDestAddr_o  = exDest;
  assign BubbleCount_o = bubbleCnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage: vector table plus
// hand-written load-use, flush, hold, saturation and reset sequences.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold, flush, decValid, decUsesRt;
  logic [4:0]  decRs, decRt, decRd;
  logic [31:0] decImm, rsData, rtData, exMem, memWb;
  logic [7:0]  decCtrl;
  logic [1:0]  rsOv, rtOv;

  logic        stall, exValid;
  logic [31:0] exRsVal, exRtVal, exImm;
  logic [7:0]  exCtrl;
  logic [4:0]  exDest;
  logic [15:0] bubbleCount;

  logic        satStall, satValid;
  logic [31:0] satRs, satRt, satImm;
  logic [7:0]  satCtrl;
  logic [4:0]  satDest;
  logic [2:0]  satCount;

  int checks = 0;
  int failures = 0;
  int expCnt = 0;
  int expSat = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk_i(clk), .rst_i(rst), .Hold_i(hold), .Flush_i(flush), .DecValid_i(decValid),
    .DecRsAddr_i(decRs), .DecRtAddr_i(decRt), .DecRdAddr_i(decRd), .DecUsesRt_i(decUsesRt),
    .DecImm_i(decImm), .DecCtrl_i(decCtrl), .RsData_i(rsData), .RtData_i(rtData),
    .DecRsOverride_i(rsOv), .DecRtOverride_i(rtOv), .ExMemAluResult_i(exMem),
    .MemWbWriteData_i(memWb), .Stall_o(stall), .ExValid_o(exValid), .ExRsVal_o(exRsVal),
    .ExRtVal_o(exRtVal), .ExImm_o(exImm), .ExCtrl_o(exCtrl), .ExDestAddr_o(exDest),
    .BubbleCount_o(bubbleCount)
  );

  id_ex_operand_stage #(.CNT_W(3)) dutSat (
    .clk_i(clk), .rst_i(rst), .Hold_i(hold), .Flush_i(flush), .DecValid_i(decValid),
    .DecRsAddr_i(decRs), .DecRtAddr_i(decRt), .DecRdAddr_i(decRd), .DecUsesRt_i(decUsesRt),
    .DecImm_i(decImm), .DecCtrl_i(decCtrl), .RsData_i(rsData), .RtData_i(rtData),
    .DecRsOverride_i(rsOv), .DecRtOverride_i(rtOv), .ExMemAluResult_i(exMem),
    .MemWbWriteData_i(memWb), .Stall_o(satStall), .ExValid_o(satValid), .ExRsVal_o(satRs),
    .ExRtVal_o(satRt), .ExImm_o(satImm), .ExCtrl_o(satCtrl), .ExDestAddr_o(satDest),
    .BubbleCount_o(satCount)
  );

  typedef struct {
    logic [1:0]  rsOv, rtOv;
    logic        valid;
    logic [7:0]  ctrl;
    logic [4:0]  rt, rd;
    logic [31:0] imm;
    logic [31:0] expRs, expRt;
    logic [7:0]  expCtrl;
    logic [4:0]  expDest;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleDecode();
    hold = 0; flush = 0; decValid = 0; decUsesRt = 0;
    decRs = 0; decRt = 0; decRd = 0; decImm = 0; decCtrl = 0;
    rsOv = 2'b00; rtOv = 2'b00;
  endtask

  task automatic decode(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic usesRt, input logic [7:0] ctrl, input logic [31:0] imm);
    decValid = 1; decRs = rs; decRt = rt; decRd = rd; decUsesRt = usesRt;
    decCtrl = ctrl; decImm = imm;
  endtask

  task automatic checkBubble(input string tag);
    check({tag, "_valid"}, {31'd0, exValid}, 32'd0);
    check({tag, "_ctrl"}, {24'd0, exCtrl}, 32'd0);
    check({tag, "_count"}, {16'd0, bubbleCount}, expCnt);
  endtask

  initial begin
    rst = 1; idleDecode();
    rsData = 32'h11; rtData = 32'h44; exMem = 32'h22; memWb = 32'h33;

    // rsOv, rtOv, valid, ctrl, rt, rd, imm, expRs, expRt, expCtrl, expDest
    vecs[0] = '{2'b10, 2'b00, 1'b1, 8'h11, 5'd2, 5'd3, 32'h0000_0100, 32'h22, 32'h44, 8'h11, 5'd3};
    vecs[1] = '{2'b01, 2'b10, 1'b1, 8'h01, 5'd2, 5'd3, 32'hFFFF_FFF0, 32'h33, 32'h22, 8'h01, 5'd2};
    vecs[2] = '{2'b00, 2'b01, 1'b1, 8'h21, 5'd6, 5'd7, 32'h0000_0007, 32'h11, 32'h33, 8'h21, 5'd6};
    vecs[3] = '{2'b11, 2'b11, 1'b1, 8'h30, 5'd6, 5'd9, 32'h0000_1234, 32'h11, 32'h44, 8'h30, 5'd9};
    vecs[4] = '{2'b10, 2'b01, 1'b0, 8'h11, 5'd4, 5'd5, 32'h0000_0055, 32'h22, 32'h33, 8'h00, 5'd5};
    vecs[5] = '{2'b00, 2'b00, 1'b1, 8'h08, 5'd12, 5'd13, 32'h8000_0000, 32'h11, 32'h44, 8'h08, 5'd12};

    tick(); tick();
    check("reset_valid", {31'd0, exValid}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_rs", exRsVal, 32'd0);
    check("reset_ctrl", {24'd0, exCtrl}, 32'd0);
    check("reset_count", {16'd0, bubbleCount}, 32'd0);
    rst = 0;

    for (int i = 0; i < 6; i++) begin
      rsOv = vecs[i].rsOv; rtOv = vecs[i].rtOv;
      decode(5'd1, vecs[i].rt, vecs[i].rd, 1'b1, vecs[i].ctrl, vecs[i].imm);
      decValid = vecs[i].valid;
      tick();
      check($sformatf("vec%0d_valid", i), {31'd0, exValid}, {31'd0, vecs[i].valid});
      check($sformatf("vec%0d_rs", i), exRsVal, vecs[i].expRs);
      check($sformatf("vec%0d_rt", i), exRtVal, vecs[i].expRt);
      check($sformatf("vec%0d_imm", i), exImm, vecs[i].imm);
      check($sformatf("vec%0d_ctrl", i), {24'd0, exCtrl}, {24'd0, vecs[i].expCtrl});
      check($sformatf("vec%0d_dest", i), {27'd0, exDest}, {27'd0, vecs[i].expDest});
      check($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
    end

    // Load-use: lw $8 in EX, add reading $8 in decode.
    idleDecode();
    decode(5'd1, 5'd8, 5'd0, 1'b0, 8'h07, 32'h4);
    tick();
    check("lw_dest", {27'd0, exDest}, 32'd8);
    decode(5'd8, 5'd9, 5'd10, 1'b1, 8'h11, 32'h0);
    #1 check("lu_stall", {31'd0, stall}, 32'd1);
    tick(); expCnt++; expSat++;
    checkBubble("lu_bubble");
    check("lu_stall_clear", {31'd0, stall}, 32'd0);
    rsOv = 2'b01;
    tick();
    check("lu_add_valid", {31'd0, exValid}, 32'd1);
    check("lu_add_rs", exRsVal, 32'h33);
    check("lu_add_dest", {27'd0, exDest}, 32'd10);
    check("lu_add_count", {16'd0, bubbleCount}, expCnt);

    // Load to $0 never stalls.
    idleDecode();
    decode(5'd1, 5'd0, 5'd0, 1'b0, 8'h07, 32'h0);
    tick();
    decode(5'd0, 5'd0, 5'd0, 1'b1, 8'h11, 32'h0);
    #1 check("zero_reg_stall", {31'd0, stall}, 32'd0);

    // rt match only counts when rt is a source; flush overrides the hazard.
    decode(5'd1, 5'd8, 5'd0, 1'b0, 8'h07, 32'h0);
    tick();
    decode(5'd1, 5'd8, 5'd10, 1'b0, 8'h11, 32'h0);
    #1 check("rt_unused_stall", {31'd0, stall}, 32'd0);
    decUsesRt = 1;
    #1 check("rt_used_stall", {31'd0, stall}, 32'd1);
    flush = 1;
    #1 check("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    checkBubble("flush_bubble");
    flush = 0;

    // Hold with a pending hazard: state and counter frozen, stall still driven.
    idleDecode();
    decode(5'd2, 5'd8, 5'd0, 1'b0, 8'h07, 32'hABCD);
    rsOv = 2'b10;
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      decode(5'd8, 5'(i + 3), 5'(i + 20), 1'b1, 8'h11, 32'(i));
      rsOv = 2'(i);
      tick();
      check($sformatf("hold%0d_rs", i), exRsVal, 32'h22);
      check($sformatf("hold%0d_imm", i), exImm, 32'hABCD);
      check($sformatf("hold%0d_ctrl", i), {24'd0, exCtrl}, 32'h07);
      check($sformatf("hold%0d_count", i), {16'd0, bubbleCount}, expCnt);
      check($sformatf("hold%0d_stall", i), {31'd0, stall}, 32'd1);
    end
    hold = 0;
    decode(5'd1, 5'd2, 5'd17, 1'b1, 8'h11, 32'h77);
    rsOv = 2'b00;
    tick();
    check("release_valid", {31'd0, exValid}, 32'd1);
    check("release_imm", exImm, 32'h77);
    check("release_dest", {27'd0, exDest}, 32'd17);

    // Repeated hazards drive the narrow counter into saturation.
    for (int i = 0; i < 8; i++) begin
      idleDecode();
      decode(5'd1, 5'd8, 5'd0, 1'b0, 8'h07, 32'h0);
      tick();
      decode(5'd8, 5'd1, 5'd3, 1'b1, 8'h11, 32'h0);
      tick();
      expCnt++;
      if (expSat < 7) expSat++;
      check($sformatf("sat%0d_count", i), {29'd0, satCount}, expSat);
    end
    check("wide_count", {16'd0, bubbleCount}, expCnt);

    // Asynchronous reset mid-stall.
    idleDecode();
    decode(5'd1, 5'd8, 5'd0, 1'b0, 8'h07, 32'h5);
    tick();
    decode(5'd8, 5'd1, 5'd3, 1'b1, 8'h11, 32'h0);
    #1 check("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_valid", {31'd0, exValid}, 32'd0);
    check("rst_imm", exImm, 32'd0);
    check("rst_ctrl", {24'd0, exCtrl}, 32'd0);
    check("rst_dest", {27'd0, exDest}, 32'd0);
    check("rst_count", {16'd0, bubbleCount}, 32'd0);
    check("rst_sat_count", {29'd0, satCount}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
